// File: rtl/exec_pkg.sv
// Purpose : shared constants, load-code enum and ALU step function for the execution-phase core.
// Latency : n/a (package); alu_step is purely combinational.
// Backpressure: n/a; the core free-runs, and nothing upstream can stall it.
package exec_pkg;

  localparam int DW = 32;
  localparam int LW = 4;

  // Opcodes (ope[31:24])
  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_POP_EBP  = 8'h5D;
  localparam logic [7:0] OP_MOV_RM   = 8'h89;
  localparam logic [7:0] OP_GRP83    = 8'h83;
  localparam logic [7:0] OP_NOP      = 8'h90;
  // Register-encoded families: the low 3 bits select the register and are ignored here.
  localparam logic [4:0] OP_INC_HI   = 5'b01000;  // 0x40-0x47
  localparam logic [4:0] OP_DEC_HI   = 5'b01001;  // 0x48-0x4F
  localparam logic [4:0] OP_MOVI_HI  = 5'b10111;  // 0xB8-0xBF

  // modrm values (ope[23:16]) that give the 0x83 group an arithmetic meaning
  localparam logic [7:0] MODRM_SUB_ESP = 8'hEC;
  localparam logic [7:0] MODRM_ADD_ESP = 8'hC4;

  typedef enum logic [LW-1:0] {
    LD_NONE  = 4'd0,
    LD_EIP   = 4'd1,
    LD_EBP   = 4'd2,
    LD_ESP   = 4'd3,
    LD_STACK = 4'd4
  } ld_code_e;

  // One ALU step. step_b selects the second result of a two-result instruction;
  // only PUSH/POP produce different values in the two steps.
  function automatic logic [DW-1:0] alu_step(
    input logic          step_b,
    input logic [7:0]    opcode,
    input logic [7:0]    modrm,
    input logic [7:0]    imm8,
    input logic [DW-1:0] imm,
    input logic [DW-1:0] opnd
  );
    logic [DW-1:0] sext8;
    logic [DW-1:0] res;
    sext8 = {{(DW-8){imm8[7]}}, imm8};
    res   = opnd;
    case (opcode)
      OP_PUSH_EBP: res = step_b ? opnd : opnd - 32'd4;
      OP_POP_EBP:  res = step_b ? opnd + 32'd4 : opnd;
      OP_MOV_RM:   res = opnd;
      OP_GRP83: begin
        if (modrm == MODRM_SUB_ESP)      res = opnd - sext8;
        else if (modrm == MODRM_ADD_ESP) res = opnd + sext8;
        else                             res = opnd;
      end
      default: begin
        if (opcode[7:3] == OP_INC_HI)       res = opnd + 32'd1;
        else if (opcode[7:3] == OP_DEC_HI)  res = opnd - 32'd1;
        else if (opcode[7:3] == OP_MOVI_HI) res = imm;
        else                                res = opnd;  // NOP and unknown opcodes
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exec_phase_ring.sv
// Purpose : 8-bit one-hot rotating phase register; bit k drives strobe clock_(k+1).
// Latency : first edge after reset releases raises bit 0; one step per clk thereafter.
// Backpressure: none; the ring advances every cycle.
// Ports   : clk, reset (sync, active-high) -> phase[7:0] one-hot (all zero while in reset).
module exec_phase_ring (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] phase
);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 8'd0;
    end else if (!$onehot(phase)) begin
      // Covers the first edge after reset and also recovers from a corrupted ring.
      phase <= 8'd1;
    end else begin
      phase <= {phase[6:0], phase[7]};
    end
  end

endmodule

// File: rtl/exec_phase_unit.sv
// Purpose : execution-timing core: 8-phase strobes, two-step ALU, destination-code selector.
// Latency : step A result/code appear on the edge ending phase 5, step B on the edge ending phase 7.
// Backpressure: none; inputs are sampled only at the phase-5/phase-7 edges.
// Ports   : clk, reset (sync, active-high); ope/imm/opnd operands; reg_load_1/2 load codes;
//           clock_1..clock_8 phase strobes; alu_result_bus + selected_reg_load registered pair.
module exec_phase_unit
  import exec_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ope,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] opnd,
  input  logic [LW-1:0] reg_load_1,
  input  logic [LW-1:0] reg_load_2,
  output logic          clock_1,
  output logic          clock_2,
  output logic          clock_3,
  output logic          clock_4,
  output logic          clock_5,
  output logic          clock_6,
  output logic          clock_7,
  output logic          clock_8,
  output logic [DW-1:0] alu_result_bus,
  output logic [LW-1:0] selected_reg_load
);

  logic [7:0]    phase;
  logic [DW-1:0] res_a;
  logic [DW-1:0] res_b;
  logic          unused_ope;

  exec_phase_ring u_ring (
    .clk   (clk),
    .reset (reset),
    .phase (phase)
  );

  assign {clock_8, clock_7, clock_6, clock_5,
          clock_4, clock_3, clock_2, clock_1} = phase;

  // The low byte of the instruction word carries nothing this core decodes.
  assign unused_ope = ^ope[7:0];

  always_comb begin
    res_a = alu_step(1'b0, ope[31:24], ope[23:16], ope[15:8], imm, opnd);
    res_b = alu_step(1'b1, ope[31:24], ope[23:16], ope[15:8], imm, opnd);
  end

  // Result and code update together so the pair is always coherent downstream.
  // Clearing the code at the end of phase 8 keeps phases 1-5 free of writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_bus    <= '0;
      selected_reg_load <= LW'(LD_NONE);
    end else if (phase[4]) begin
      alu_result_bus    <= res_a;
      selected_reg_load <= reg_load_1;
    end else if (phase[6]) begin
      alu_result_bus    <= res_b;
      selected_reg_load <= reg_load_2;
    end else if (phase[7]) begin
      selected_reg_load <= LW'(LD_NONE);
    end
  end

endmodule

// File: tb/tb_exec_phase_unit.sv
// Bench for exec_phase_unit: phase-number model plus directed instruction vectors.
module tb_exec_phase_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ope, imm, opnd;
  logic [3:0]  reg_load_1, reg_load_2;
  logic        c1, c2, c3, c4, c5, c6, c7, c8;
  logic [31:0] alu_result_bus;
  logic [3:0]  selected_reg_load;
  logic [7:0]  strobes;

  int errors = 0;
  int checks = 0;

  // Model state: phase number 0 (in reset) or 1..8, expected result and code.
  int          m_phase = 0;
  logic [31:0] m_res   = '0;
  logic [3:0]  m_code  = '0;
  bit          m_valid = 1'b0;

  exec_phase_unit dut (
    .clk               (clk),
    .reset             (reset),
    .ope               (ope),
    .imm               (imm),
    .opnd              (opnd),
    .reg_load_1        (reg_load_1),
    .reg_load_2        (reg_load_2),
    .clock_1           (c1),
    .clock_2           (c2),
    .clock_3           (c3),
    .clock_4           (c4),
    .clock_5           (c5),
    .clock_6           (c6),
    .clock_7           (c7),
    .clock_8           (c8),
    .alu_result_bus    (alu_result_bus),
    .selected_reg_load (selected_reg_load)
  );

  assign strobes = {c8, c7, c6, c5, c4, c3, c2, c1};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction semantics straight from the opcode table.
  function automatic logic [31:0] model_alu(input bit second, input logic [31:0] o,
                                            input logic [31:0] im, input logic [31:0] r);
    int unsigned op, mr;
    int          s8;
    op = o[31:24];
    mr = o[23:16];
    s8 = int'(o[15:8]);
    if (s8 >= 128) s8 = s8 - 256;
    if (op == 'h55)               return second ? r : r - 32'd4;
    if (op == 'h5D)               return second ? r + 32'd4 : r;
    if (op == 'h83 && mr == 'hEC) return r - 32'(s8);
    if (op == 'h83 && mr == 'hC4) return r + 32'(s8);
    if (op >= 'h40 && op <= 'h47) return r + 32'd1;
    if (op >= 'h48 && op <= 'h4F) return r - 32'd1;
    if (op >= 'hB8 && op <= 'hBF) return im;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_res   = '0;
      m_code  = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_phase == 5) begin
        m_res  = model_alu(1'b0, ope, imm, opnd);
        m_code = reg_load_1;
      end else if (m_phase == 7) begin
        m_res  = model_alu(1'b1, ope, imm, opnd);
        m_code = reg_load_2;
      end else if (m_phase == 8) begin
        m_code = '0;
      end
      m_phase = (m_phase == 0 || m_phase == 8) ? 1 : m_phase + 1;
    end
  end

  // Every-cycle comparison against the model once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("strobes", 32'(strobes), (m_phase == 0) ? 32'd0 : (32'd1 << (m_phase - 1)));
      check("result",  alu_result_bus, m_res);
      check("code",    32'(selected_reg_load), 32'(m_code));
    end
  end

  task automatic wait_phase(input int p);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (strobes == (8'd1 << (p - 1))) found = 1'b1;
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL wait_phase%0d: strobe never seen, strobes=%b", p, strobes);
    end
  endtask

  task automatic run_instr(input string name, input logic [31:0] o, input logic [31:0] im,
                           input logic [31:0] r, input logic [3:0] l1, input logic [3:0] l2,
                           input logic [31:0] exp_a, input logic [31:0] exp_b);
    wait_phase(1);
    ope = o; imm = im; opnd = r; reg_load_1 = l1; reg_load_2 = l2;
    wait_phase(6);
    check({name, "_A"}, alu_result_bus, exp_a);
    check({name, "_codeA"}, 32'(selected_reg_load), 32'(l1));
    // Operands moved outside the sampling edges must not disturb step B.
    wait_phase(8);
    ope = 32'h90000000; opnd = 32'h5A5A5A5A; imm = 32'hA5A5A5A5;
    check({name, "_B"}, alu_result_bus, exp_b);
    check({name, "_codeB"}, 32'(selected_reg_load), 32'(l2));
    wait_phase(1);
    check({name, "_code_cleared"}, 32'(selected_reg_load), 32'd0);
  endtask

  initial begin
    logic [7:0] seq_exp;
    reset = 1'b1; ope = '0; imm = '0; opnd = '0; reg_load_1 = '0; reg_load_2 = '0;

    repeat (2) begin
      @(negedge clk);
      check("rst_strobes", 32'(strobes), 32'd0);
      check("rst_result", alu_result_bus, 32'd0);
      check("rst_code", 32'(selected_reg_load), 32'd0);
    end
    reset = 1'b0;

    seq_exp = 8'h01;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("sequence", 32'(strobes), 32'(seq_exp));
      seq_exp = {seq_exp[6:0], seq_exp[7]};
    end

    run_instr("push",     32'h55000000, 32'd0,        32'h00001000, 4'd3, 4'd4, 32'h00000FFC, 32'h00001000);
    run_instr("push_wrap",32'h55000000, 32'd0,        32'h00000000, 4'd3, 4'd4, 32'hFFFFFFFC, 32'h00000000);
    run_instr("pop",      32'h5D000000, 32'd0,        32'h00002000, 4'd2, 4'd3, 32'h00002000, 32'h00002004);
    run_instr("sub_esp",  32'h83EC1000, 32'd0,        32'h00000100, 4'd3, 4'd3, 32'h000000F0, 32'h000000F0);
    run_instr("sub_neg",  32'h83ECF000, 32'd0,        32'h00000100, 4'd3, 4'd0, 32'h00000110, 32'h00000110);
    run_instr("add_esp",  32'h83C40800, 32'd0,        32'h00000100, 4'd3, 4'd3, 32'h00000108, 32'h00000108);
    run_instr("grp83_oth",32'h83E01000, 32'd0,        32'h00000777, 4'd1, 4'd2, 32'h00000777, 32'h00000777);
    run_instr("dec",      32'h48000000, 32'd0,        32'h00000000, 4'd2, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_instr("inc",      32'h40000000, 32'd0,        32'hFFFFFFFF, 4'd3, 4'd3, 32'h00000000, 32'h00000000);
    run_instr("movi",     32'hB8000000, 32'h12345678, 32'h00000001, 4'd1, 4'd4, 32'h12345678, 32'h12345678);
    run_instr("mov_rm",   32'h89000000, 32'd0,        32'hDEADBEEF, 4'd4, 4'd2, 32'hDEADBEEF, 32'hDEADBEEF);
    run_instr("unknown",  32'hFF000000, 32'd0,        32'hCAFEBABE, 4'd15, 4'd5, 32'hCAFEBABE, 32'hCAFEBABE);

    // Reset in the middle of an instruction.
    wait_phase(1);
    ope = 32'h55000000; opnd = 32'h00003000; reg_load_1 = 4'd3; reg_load_2 = 4'd4;
    wait_phase(6);
    check("pre_abort_result", alu_result_bus, 32'h00002FFC);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", 32'(strobes), 32'd0);
    check("abort_result", alu_result_bus, 32'd0);
    check("abort_code", 32'(selected_reg_load), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("restart_clock_1", 32'(strobes), 32'h01);
    repeat (9) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
